io_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the single slave port of the I/O bridge among NMST Wishbone-style masters (CPU data port, CPU instruction port, DMA, debug).
- Grants one master at a time and holds the grant for as long as that master keeps cyc asserted, which gives locked multi-access sequences.
- Returns a bus error if the bridge does not acknowledge within TIMEOUT cycles. Sits between the masters and the bridge slave port.

---
 rtl/io_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the I/O bridge slave port among NMST Wishbone-style masters.
// A grant is held for as long as the owner keeps cyc high; a silent bridge yields a bus-timeout error.
module io_bus_arbiter #(
    parameter int NMST    = 4,
    parameter int TIMEOUT = 255,
    parameter int TBITS   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NMST-1:0]       m_cyc_i,
    input  logic [NMST-1:0]       m_stb_i,
    input  logic [NMST-1:0]       m_we_i,
    input  logic [16*NMST-1:0]    m_sel_i,
    input  logic [32*NMST-1:0]    m_adr_i,
    input  logic [128*NMST-1:0]   m_dat_i,
    output logic [NMST-1:0]       m_ack_o,
    output logic [NMST-1:0]       m_err_o,
    output logic [NMST-1:0]       m_gnt_o,
    output logic [127:0]          m_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [15:0]           s_sel_o,
    output logic [31:0]           s_adr_o,
    output logic [127:0]          s_dat_o,
    input  logic                  s_ack_i,
    input  logic [127:0]          s_dat_i
);

    localparam int               IW    = (NMST > 1) ? $clog2(NMST) : 1;
    localparam logic [TBITS-1:0] TLAST = TBITS'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [NMST-1:0]   gnt_q, gnt_d;
    logic [NMST-1:0]   err_q, err_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     last_q, last_d;
    logic [TBITS-1:0]  tcnt_q, tcnt_d;

    logic [NMST-1:0]   req;
    logic              sel_cyc, sel_stb, sel_we;
    logic [15:0]       sel_sel;
    logic [31:0]       sel_adr;
    logic [127:0]      sel_dat;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [NMST-1:0]   pick_oh;

    assign req = m_cyc_i & m_stb_i;

    // Constant-slice mux keyed on the registered owner index.
    always_comb begin : owner_mux
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_sel = '0;
        sel_adr = '0;
        sel_dat = '0;
        for (int k = 0; k < NMST; k++) begin
            if (gidx_q == IW'(k)) begin
                sel_cyc = m_cyc_i[k];
                sel_stb = m_stb_i[k];
                sel_we  = m_we_i[k];
                sel_sel = m_sel_i[16*k +: 16];
                sel_adr = m_adr_i[32*k +: 32];
                sel_dat = m_dat_i[128*k +: 128];
            end
        end
    end

    always_comb begin : rr_pick
        logic [IW-1:0] cand;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NMST; i++) begin
            cand = IW'((int'(last_q) + i) % NMST);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        for (int k = 0; k < NMST; k++) begin
            pick_oh[k] = (pick_idx == IW'(k));
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        tcnt_d  = '0;
        err_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gidx_d  = pick_idx;
                    gnt_d   = pick_oh;
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (s_ack_i || !sel_stb) begin
                    tcnt_d = '0;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else begin
                    tcnt_d = tcnt_q;
                end
                if (!sel_cyc) begin
                    last_d  = gidx_q;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else if (sel_stb && !s_ack_i && tcnt_q == TLAST) begin
                    // gnt_q is one-hot on the owner, so it doubles as the error vector.
                    err_d   = gnt_q;
                    tcnt_d  = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!sel_cyc) begin
                    last_d  = gidx_q;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : slave_side
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        if (state_q == S_OWN) begin
            s_cyc_o = sel_cyc;
            s_stb_o = sel_stb;
            s_we_o  = sel_we;
            s_sel_o = sel_sel;
            s_adr_o = sel_adr;
            s_dat_o = sel_dat;
            m_ack_o = gnt_q & {NMST{s_ack_i & sel_stb}};
        end
    end

    assign m_gnt_o = gnt_q;
    assign m_err_o = err_q;
    assign m_dat_o = s_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            err_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NMST - 1);
            tcnt_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: reset, single read, round robin, locked owner,
// bus timeout, ack racing the timeout, and asynchronous reset mid-transfer.
module tb_io_bus_arbiter;

    localparam int NMST    = 4;
    localparam int TIMEOUT = 8;
    localparam int TBITS   = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [NMST-1:0]      m_cyc, m_stb, m_we;
    logic [16*NMST-1:0]   m_sel;
    logic [32*NMST-1:0]   m_adr;
    logic [128*NMST-1:0]  m_dat;
    logic [NMST-1:0]      m_ack_o, m_err_o, m_gnt_o;
    logic [127:0]         m_dat_o;
    logic                 s_cyc_o, s_stb_o, s_we_o;
    logic [15:0]          s_sel_o;
    logic [31:0]          s_adr_o;
    logic [127:0]         s_dat_o;
    logic                 s_ack;
    logic [127:0]         s_dat;

    int checks   = 0;
    int failures = 0;

    io_bus_arbiter #(.NMST(NMST), .TIMEOUT(TIMEOUT), .TBITS(TBITS)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_sel_i (m_sel),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_gnt_o (m_gnt_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_sel_o (s_sel_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_ack_i (s_ack),
        .s_dat_i (s_dat)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0;
        m_cyc  = '0;
        m_stb  = '0;
        s_ack  = 1'b0;
        s_dat  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        m_cyc  = 4'b1111;
        m_stb  = 4'b1111;
        s_ack  = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", m_gnt_o); end
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin failures++; $display("FAIL reset_s_ctrl: got cyc=%b stb=%b expected 0 0", s_cyc_o, s_stb_o); end
        checks++; if (m_ack_o !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b expected 0000", m_ack_o); end
        checks++; if (m_err_o !== 4'b0000) begin failures++; $display("FAIL reset_err: got %b expected 0000", m_err_o); end
    endtask

    task automatic test_single_read();
        reset_dut();
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0000) begin failures++; $display("FAIL sr_gnt_pre: got %b expected 0000", m_gnt_o); end
        tick();
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0001) begin failures++; $display("FAIL sr_gnt: got %b expected 0001", m_gnt_o); end
        checks++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) begin failures++; $display("FAIL sr_s_ctrl: got cyc=%b stb=%b expected 1 1", s_cyc_o, s_stb_o); end
        checks++; if (s_adr_o !== 32'hA000_0000 || s_we_o !== 1'b0) begin failures++; $display("FAIL sr_adr_we: got %h/%b expected a0000000/0", s_adr_o, s_we_o); end
        tick();
        tick();
        s_ack = 1'b1;
        s_dat = 128'h0123_4567_89AB_CDEF_0000_0000_0000_DEAD;
        @(negedge clk_i);
        checks++; if (m_ack_o !== 4'b0001) begin failures++; $display("FAIL sr_ack: got %b expected 0001", m_ack_o); end
        checks++; if (m_dat_o !== 128'h0123_4567_89AB_CDEF_0000_0000_0000_DEAD) begin failures++; $display("FAIL sr_rdata: got %h expected ...dead", m_dat_o); end
        tick();
        s_ack    = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(negedge clk_i);
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL sr_cyc_drop: got %b expected 0", s_cyc_o); end
        checks++; if (m_gnt_o !== 4'b0001) begin failures++; $display("FAIL sr_gnt_hold: got %b expected 0001", m_gnt_o); end
        tick();
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0000) begin failures++; $display("FAIL sr_gnt_release: got %b expected 0000", m_gnt_o); end
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack_o !== 4'b0000) begin failures++; $display("FAIL sr_stray_ack_idle: got %b expected 0000", m_ack_o); end
        s_ack = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        int         g;
        reset_dut();
        m_cyc = 4'b1111;
        m_stb = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            g       = i % NMST;
            exp_gnt = 4'b0001 << g;
            tick();
            s_ack = 1'b1;
            @(negedge clk_i);
            checks++; if (m_gnt_o !== exp_gnt) begin failures++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, m_gnt_o, exp_gnt); end
            checks++; if (m_ack_o !== exp_gnt) begin failures++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, m_ack_o, exp_gnt); end
            tick();
            s_ack    = 1'b0;
            m_cyc[g] = 1'b0;
            m_stb[g] = 1'b0;
            @(negedge clk_i);
            checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rr_cyc_drop[%0d]: got %b expected 0", i, s_cyc_o); end
            tick();
            m_cyc[g] = 1'b1;
            m_stb[g] = 1'b1;
            @(negedge clk_i);
            checks++; if (m_gnt_o !== 4'b0000) begin failures++; $display("FAIL rr_dead[%0d]: got %b expected 0000", i, m_gnt_o); end
        end
    endtask

    task automatic test_locked();
        reset_dut();
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        tick();
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        @(negedge clk_i);
        checks++; if (s_adr_o !== 32'hA000_0002 || s_sel_o !== 16'h3333) begin failures++; $display("FAIL lk_adr_sel: got %h/%h expected a0000002/3333", s_adr_o, s_sel_o); end
        checks++; if (s_dat_o !== {96'h0, 32'hC0DE_0002} || s_we_o !== 1'b0) begin failures++; $display("FAIL lk_dat_we: got %h/%b expected c0de0002/0", s_dat_o, s_we_o); end
        for (int s = 0; s < 4; s++) begin
            m_stb[2] = 1'b1;
            s_ack    = 1'b1;
            @(negedge clk_i);
            checks++; if (m_ack_o !== 4'b0100) begin failures++; $display("FAIL lk_ack[%0d]: got %b expected 0100", s, m_ack_o); end
            checks++; if (m_gnt_o !== 4'b0100) begin failures++; $display("FAIL lk_gnt[%0d]: got %b expected 0100", s, m_gnt_o); end
            tick();
            s_ack    = 1'b0;
            m_stb[2] = 1'b0;
            @(negedge clk_i);
            checks++; if (m_gnt_o !== 4'b0100 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b0) begin
                failures++; $display("FAIL lk_gap[%0d]: got gnt=%b cyc=%b stb=%b expected 0100 1 0", s, m_gnt_o, s_cyc_o, s_stb_o);
            end
            tick();
        end
        m_cyc[2] = 1'b0;
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0100 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL lk_drop: got gnt=%b cyc=%b expected 0100 0", m_gnt_o, s_cyc_o); end
        tick();
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0000) begin failures++; $display("FAIL lk_dead: got %b expected 0000", m_gnt_o); end
        tick();
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0010 || s_adr_o !== 32'hA000_0001) begin failures++; $display("FAIL lk_next: got %b/%h expected 0010/a0000001", m_gnt_o, s_adr_o); end
    endtask

    task automatic test_timeout();
        reset_dut();
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        tick();
        @(negedge clk_i);
        checks++; if (s_we_o !== 1'b1 || m_gnt_o !== 4'b0010) begin failures++; $display("FAIL to_start: got we=%b gnt=%b expected 1 0010", s_we_o, m_gnt_o); end
        repeat (TIMEOUT - 1) tick();
        @(negedge clk_i);
        checks++; if (m_err_o !== 4'b0000 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL to_last_strobe: got err=%b cyc=%b expected 0000 1", m_err_o, s_cyc_o); end
        tick();
        @(negedge clk_i);
        checks++; if (m_err_o !== 4'b0010) begin failures++; $display("FAIL to_err: got %b expected 0010", m_err_o); end
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_gnt_o !== 4'b0010) begin
            failures++; $display("FAIL to_flush: got cyc=%b stb=%b gnt=%b expected 0 0 0010", s_cyc_o, s_stb_o, m_gnt_o);
        end
        tick();
        s_ack    = 1'b1;
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        @(negedge clk_i);
        checks++; if (m_err_o !== 4'b0000) begin failures++; $display("FAIL to_err_pulse: got %b expected 0000", m_err_o); end
        checks++; if (m_ack_o !== 4'b0000 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL to_stray_ack: got ack=%b cyc=%b expected 0000 0", m_ack_o, s_cyc_o); end
        tick();
        s_ack    = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0010) begin failures++; $display("FAIL to_flush_hold: got %b expected 0010", m_gnt_o); end
        tick();
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0000) begin failures++; $display("FAIL to_idle: got %b expected 0000", m_gnt_o); end
        tick();
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0100 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL to_next: got gnt=%b cyc=%b expected 0100 1", m_gnt_o, s_cyc_o); end
    endtask

    task automatic test_ack_on_timeout();
        reset_dut();
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        tick();
        repeat (TIMEOUT - 1) tick();
        s_ack = 1'b1;
        @(negedge clk_i);
        checks++; if (m_ack_o !== 4'b0001 || m_err_o !== 4'b0000) begin failures++; $display("FAIL at_race: got ack=%b err=%b expected 0001 0000", m_ack_o, m_err_o); end
        tick();
        s_ack = 1'b0;
        @(negedge clk_i);
        checks++; if (m_err_o !== 4'b0000 || s_cyc_o !== 1'b1 || m_gnt_o !== 4'b0001) begin
            failures++; $display("FAIL at_after: got err=%b cyc=%b gnt=%b expected 0000 1 0001", m_err_o, s_cyc_o, m_gnt_o);
        end
        repeat (TIMEOUT - 1) tick();
        @(negedge clk_i);
        checks++; if (m_err_o !== 4'b0000) begin failures++; $display("FAIL at_restart_early: got %b expected 0000", m_err_o); end
        tick();
        @(negedge clk_i);
        checks++; if (m_err_o !== 4'b0001) begin failures++; $display("FAIL at_restart_fire: got %b expected 0001", m_err_o); end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        reset_dut();
        m_cyc[3] = 1'b1;
        m_stb[3] = 1'b1;
        tick();
        s_ack = 1'b1;
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b1000 || m_ack_o !== 4'b1000) begin failures++; $display("FAIL rm_owner: got gnt=%b ack=%b expected 1000 1000", m_gnt_o, m_ack_o); end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++; if (m_gnt_o !== 4'b0000 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL rm_abort: got gnt=%b cyc=%b expected 0000 0", m_gnt_o, s_cyc_o); end
        checks++; if (m_ack_o !== 4'b0000 || m_err_o !== 4'b0000) begin failures++; $display("FAIL rm_quiet: got ack=%b err=%b expected 0000 0000", m_ack_o, m_err_o); end
        @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        s_ack    = 1'b0;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        tick();
        @(negedge clk_i);
        checks++; if (m_gnt_o !== 4'b0001) begin failures++; $display("FAIL rm_regrant: got %b expected 0001", m_gnt_o); end
    endtask

    initial begin
        m_cyc = '0;
        m_stb = '0;
        m_we  = 4'b1010;
        s_ack = 1'b0;
        s_dat = '0;
        for (int k = 0; k < NMST; k++) begin
            m_sel[16*k +: 16]   = 16'(16'h1111 * (k + 1));
            m_adr[32*k +: 32]   = 32'hA000_0000 + 32'(k);
            m_dat[128*k +: 128] = {96'h0, 32'hC0DE_0000 + 32'(k)};
        end
        test_reset();
        test_single_read();
        test_round_robin();
        test_locked();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
